// File: rtl/mem_arbiter.sv
// Two-master (CPU / DMA) arbiter for a single-port memory with round-robin tie-break.
// Each access runs IDLE -> ACCESS -> DONE; every output is registered.
module mem_arbiter #(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [AWIDTH-1:0] cpu_addr,
   input  logic [DWIDTH-1:0] cpu_wdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [AWIDTH-1:0] dma_addr,
   input  logic [DWIDTH-1:0] dma_wdata,
   output logic              cpu_gnt,
   output logic              dma_gnt,
   output logic              cpu_ack,
   output logic              dma_ack,
   output logic [DWIDTH-1:0] rdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   output logic              mem_data_e,
   input  logic [DWIDTH-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [1:0]        state;
   logic              prio_dma;
   logic              we_q;

   logic              pick_dma;
   logic              sel_we;
   logic [AWIDTH-1:0] sel_addr;
   logic [DWIDTH-1:0] sel_wdata;

   // DMA wins when it is alone, or on a tie when it holds the round-robin token.
   always_comb begin
      pick_dma  = dma_req & (~cpu_req | prio_dma);
      sel_we    = pick_dma ? dma_we    : cpu_we;
      sel_addr  = pick_dma ? dma_addr  : cpu_addr;
      sel_wdata = pick_dma ? dma_wdata : cpu_wdata;
   end

   // NOTE: all state and outputs use non-blocking assignments so every register
   // samples pre-edge values; blocking here would create ordering-dependent logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         prio_dma   <= 1'b0;
         we_q       <= 1'b0;
         cpu_gnt    <= 1'b0;
         dma_gnt    <= 1'b0;
         cpu_ack    <= 1'b0;
         dma_ack    <= 1'b0;
         rdata      <= '0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_data_e <= 1'b0;
         busy       <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         dma_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cpu_req | dma_req) begin
                  state      <= ST_ACCESS;
                  busy       <= 1'b1;
                  cpu_gnt    <= ~pick_dma;
                  dma_gnt    <= pick_dma;
                  prio_dma   <= ~pick_dma;
                  we_q       <= sel_we;
                  mem_addr   <= sel_addr;
                  mem_wdata  <= sel_wdata;
                  mem_rd     <= ~sel_we;
                  mem_wr     <= sel_we;
                  mem_data_e <= sel_we;
               end
            end
            ST_ACCESS: begin
               state      <= ST_DONE;
               mem_rd     <= 1'b0;
               mem_wr     <= 1'b0;
               mem_data_e <= 1'b0;
               cpu_ack    <= cpu_gnt;
               dma_ack    <= dma_gnt;
               if (!we_q) rdata <= mem_rdata;
            end
            ST_DONE: begin
               // No grant here: the just-acked master's req may still be high.
               state   <= ST_IDLE;
               busy    <= 1'b0;
               cpu_gnt <= 1'b0;
               dma_gnt <= 1'b0;
            end
            default: begin
               state      <= ST_IDLE;
               busy       <= 1'b0;
               cpu_gnt    <= 1'b0;
               dma_gnt    <= 1'b0;
               mem_rd     <= 1'b0;
               mem_wr     <= 1'b0;
               mem_data_e <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected accesses, a negedge
// monitor checks every memory strobe and every ack against the queue head.
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpu_req, cpu_we, dma_req, dma_we;
   logic [4:0] cpu_addr, dma_addr;
   logic [7:0] cpu_wdata, dma_wdata;
   logic       cpu_gnt, dma_gnt, cpu_ack, dma_ack;
   logic [7:0] rdata;
   logic       mem_rd, mem_wr, mem_data_e, busy;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.AWIDTH(5), .DWIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .cpu_ack(cpu_ack), .dma_ack(dma_ack),
      .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_data_e(mem_data_e), .mem_rdata(mem_rdata), .busy(busy)
   );

   // Memory model: combinational read of the presented address, write on the edge.
   logic [7:0] mem [32];
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

   typedef struct {
      logic       is_dma;
      logic       we;
      logic [4:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [7:0] ref_mem [32];
   logic [7:0] last_rd;
   logic       model_prio;
   logic       mon_en = 1'b0;
   int         tests = 0;
   int         fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic is_dma, input logic we, input logic [4:0] a,
                           input logic [7:0] d);
      exp_t e;
      e.is_dma = is_dma;
      e.we     = we;
      e.addr   = a;
      e.wdata  = d;
      if (we) ref_mem[a] = d;
      else    last_rd = ref_mem[a];
      e.exp_rdata = last_rd;
      sb.push_back(e);
      model_prio = !is_dma;
   endtask

   task automatic cpu_access(input logic we, input logic [4:0] a, input logic [7:0] d);
      logic got = 1'b0;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #1;
         if (cpu_ack) got = 1'b1;
      end
      cpu_req = 1'b0;
      check("cpu_ack_arrived", 32'(got), 1);
   endtask

   task automatic dma_access(input logic we, input logic [4:0] a, input logic [7:0] d);
      logic got = 1'b0;
      @(posedge clk); #1;
      dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #1;
         if (dma_ack) got = 1'b1;
      end
      dma_req = 1'b0;
      check("dma_ack_arrived", 32'(got), 1);
   endtask

   // Monitor: invariants every cycle, strobes and acks against the scoreboard head.
   always @(negedge clk) begin
      if (mon_en) begin
         check("gnt_exclusive", 32'(cpu_gnt & dma_gnt), 0);
         check("ack_exclusive", 32'(cpu_ack & dma_ack), 0);
         check("strobe_exclusive", 32'(mem_rd & mem_wr), 0);
         if (mem_rd | mem_wr) begin
            check("sb_nonempty_at_strobe", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               mon_e = sb[0];
               check("access_wr", 32'(mem_wr), 32'(mon_e.we));
               check("access_data_e", 32'(mem_data_e), 32'(mon_e.we));
               check("access_addr", 32'(mem_addr), 32'(mon_e.addr));
               check("access_gnt_dma", 32'(dma_gnt), 32'(mon_e.is_dma));
               check("access_gnt_cpu", 32'(cpu_gnt), 32'(!mon_e.is_dma));
               if (mon_e.we) check("access_wdata", 32'(mem_wdata), 32'(mon_e.wdata));
            end
         end
         if (cpu_ack | dma_ack) begin
            check("sb_nonempty_at_ack", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               check("ack_is_dma", 32'(dma_ack), 32'(mon_e.is_dma));
               check("ack_rdata", 32'(rdata), 32'(mon_e.exp_rdata));
               check("ack_strobes_low", 32'({mem_rd, mem_wr, mem_data_e}), 0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int         ack_cyc [4];
      int         n_ack;
      logic       r_we_c, r_we_d;
      logic [4:0] r_a_c, r_a_d;
      logic [7:0] r_d_c, r_d_d;
      int         kind;

      for (int i = 0; i < 32; i++) begin
         mem[i]     = 8'(i * 37 + 11);
         ref_mem[i] = 8'(i * 37 + 11);
      end
      mem[3] = 8'hA5; ref_mem[3] = 8'hA5;
      last_rd = 8'h00; model_prio = 1'b0;
      rst = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_outputs", 32'({cpu_gnt, dma_gnt, cpu_ack, dma_ack, mem_rd, mem_wr, mem_data_e, busy}), 0);
      check("rst_rdata", 32'(rdata), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
      rst = 1'b0;
      mon_en = 1'b1;

      // CPU read of 0x03 with exact latency checks
      push_exp(1'b0, 1'b0, 5'h03, 8'h00);
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h03;
      @(posedge clk); #1;
      check("lat_mem_rd_n1", 32'(mem_rd), 1);
      check("lat_busy_n1", 32'(busy), 1);
      check("lat_cpu_ack_n1", 32'(cpu_ack), 0);
      @(posedge clk); #1;
      check("lat_cpu_ack_n2", 32'(cpu_ack), 1);
      check("lat_rdata_n2", 32'(rdata), 32'h A5);
      check("lat_gnt_done", 32'(cpu_gnt), 1);
      cpu_req = 1'b0;
      @(posedge clk); #1;
      check("lat_busy_n3", 32'(busy), 0);
      check("lat_ack_n3", 32'(cpu_ack), 0);

      // DMA write of 0x3C to 0x1F; rdata keeps 0xA5
      push_exp(1'b1, 1'b1, 5'h1F, 8'h3C);
      dma_access(1'b1, 5'h1F, 8'h3C);
      check("dma_wr_rdata_kept", 32'(rdata), 32'h A5);

      // Both requesting continuously: C, D, C, D, acks 3 cycles apart
      push_exp(1'b0, 1'b0, 5'h0A, 8'h00);
      push_exp(1'b1, 1'b1, 5'h10, 8'h11);
      push_exp(1'b0, 1'b0, 5'h0A, 8'h00);
      push_exp(1'b1, 1'b1, 5'h10, 8'h22);
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h0A; cpu_wdata = 8'h00;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 5'h10; dma_wdata = 8'h11;
      n_ack = 0;
      for (int c = 0; c < 40 && n_ack < 4; c++) begin
         @(posedge clk); #1;
         if (cpu_ack | dma_ack) begin
            ack_cyc[n_ack] = c;
            n_ack++;
            if (dma_ack) dma_wdata = 8'h22;
         end
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      check("both_ack_count", 32'(n_ack), 4);
      for (int k = 1; k < 4; k++) check("both_ack_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 3);
      repeat (2) @(posedge clk);

      // CPU req withdrawn in ACCESS with attributes changed: access still completes
      push_exp(1'b0, 1'b0, 5'h05, 8'h00);
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h05;
      @(posedge clk); #1;
      cpu_req = 1'b0; cpu_we = 1'b1; cpu_addr = 5'h1E;
      @(posedge clk); #1;
      check("withdraw_ack", 32'(cpu_ack), 1);
      @(posedge clk); #1;
      check("withdraw_busy_idle", 32'(busy), 0);
      @(posedge clk); #1;
      check("withdraw_stays_idle", 32'({busy, cpu_gnt, mem_rd, mem_wr}), 0);

      // Reset during ACCESS of a CPU write (prio_dma is 1 at this point)
      push_exp(1'b0, 1'b1, 5'h07, 8'h99);
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h07; cpu_wdata = 8'h99;
      @(posedge clk); #1;
      check("abort_mem_wr_before", 32'(mem_wr), 1);
      rst = 1'b1; cpu_req = 1'b0;
      @(posedge clk); #1;
      check("abort_mem_wr_dropped", 32'(mem_wr), 0);
      check("abort_no_ack", 32'({cpu_ack, dma_ack}), 0);
      check("abort_idle", 32'({busy, cpu_gnt, dma_gnt}), 0);
      check("abort_rdata_cleared", 32'(rdata), 0);
      sb.delete();
      last_rd = 8'h00; model_prio = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort_no_late_ack", 32'({cpu_ack, dma_ack}), 0);

      // Tie after reset: CPU must win (prio_dma cleared by reset)
      push_exp(1'b0, 1'b0, 5'h01, 8'h00);
      push_exp(1'b1, 1'b0, 5'h02, 8'h00);
      fork
         cpu_access(1'b0, 5'h01, 8'h00);
         dma_access(1'b0, 5'h02, 8'h00);
      join

      // Random traffic: order predicted from the bench's own round-robin model
      for (int it = 0; it < 30; it++) begin
         kind   = $urandom_range(0, 2);
         r_we_c = 1'($urandom_range(0, 1)); r_a_c = 5'($urandom); r_d_c = 8'($urandom);
         r_we_d = 1'($urandom_range(0, 1)); r_a_d = 5'($urandom); r_d_d = 8'($urandom);
         if (kind == 0) begin
            push_exp(1'b0, r_we_c, r_a_c, r_d_c);
            cpu_access(r_we_c, r_a_c, r_d_c);
         end else if (kind == 1) begin
            push_exp(1'b1, r_we_d, r_a_d, r_d_d);
            dma_access(r_we_d, r_a_d, r_d_d);
         end else begin
            if (model_prio) begin
               push_exp(1'b1, r_we_d, r_a_d, r_d_d);
               push_exp(1'b0, r_we_c, r_a_c, r_d_c);
            end else begin
               push_exp(1'b0, r_we_c, r_a_c, r_d_c);
               push_exp(1'b1, r_we_d, r_a_d, r_d_d);
            end
            fork
               cpu_access(r_we_c, r_a_c, r_d_c);
               dma_access(r_we_d, r_a_d, r_d_d);
            join
         end
      end

      repeat (4) @(posedge clk);
      #1;
      check("sb_drained", 32'(sb.size()), 0);
      check("final_idle", 32'(busy), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
